// File: rtl/bsg_g2b_rr_arb.sv
// Round-robin arbiter with a last-winner pointer.
// Search starts at last+1 (mod els_p); the pointer moves only on a real grant
// and resets to els_p-1 so requester 0 has first priority.
// Ports:
//   clk_i      in  1             clock
//   reset_n_i  in  1             asynchronous active-low reset
//   en_i       in  1             grant permitted this cycle
//   v_i        in  els_p         request vector
//   grant_o    out els_p         one-hot/zero grant
//   tag_o      out tag_width_lp  index of the winner (valid when grant_o != 0)
module bsg_g2b_rr_arb #(
  parameter  int els_p        = 4,
  localparam int tag_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [els_p-1:0]        v_i,
  output logic [els_p-1:0]        grant_o,
  output logic [tag_width_lp-1:0] tag_o
);

  logic [tag_width_lp-1:0] last_r;
  logic [tag_width_lp-1:0] idx;
  logic                    found;

  always_comb begin
    grant_o = '0;
    tag_o   = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= unsigned'(els_p); i++) begin
      idx = tag_width_lp'((32'(last_r) + i) % unsigned'(els_p));
      if (!found && v_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        tag_o        = idx;
      end
    end
    // No grant while the pipeline cannot take a word, or while held in reset.
    if (!(en_i && reset_n_i)) begin
      grant_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r <= tag_width_lp'(els_p - 1);
    end else if (|grant_o) begin
      last_r <= tag_o;
    end
  end

endmodule

// File: rtl/bsg_gray_to_binary.sv
// Gray-to-binary converter (combinational).
// Each binary bit is the XOR of the gray bits from that position up to the MSB,
// i.e. b[msb] = g[msb], b[i] = g[i] ^ b[i+1].
// Ports:
//   gray_i    in  width_p  gray-coded word
//   binary_o  out width_p  binary equivalent
module bsg_gray_to_binary #(
  parameter int width_p = 16
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  // Written as a reduction of the shifted word rather than the ripple
  // recurrence so there is no self-referencing combinational vector.
  always_comb begin
    binary_o = '0;
    for (int unsigned i = 0; i < width_p; i++) begin
      binary_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/bsg_gray_to_binary_rr_shared.sv
// One gray-to-binary converter shared among els_p requesters.
// Round-robin grant -> S1 (capture gray word + tag) -> convert -> S2 (registered
// binary word + tag). Grant at cycle N gives v_o at N+2 when not stalled;
// sustains one word per cycle with ready_i=1.
// Ports:
//   clk_i      in  1                clock
//   reset_n_i  in  1                asynchronous active-low reset
//   v_i        in  els_p            per-requester valid
//   gray_i     in  els_p*width_p    requester k's word at [k*width_p +: width_p]
//   yumi_o     out els_p            one-hot/zero grant (word consumed)
//   v_o        out 1                output valid
//   binary_o   out width_p          converted word
//   tag_o      out tag_width_lp     requester index of binary_o
//   ready_i    in  1                downstream accept
module bsg_gray_to_binary_rr_shared #(
  parameter  int width_p      = 16,
  parameter  int els_p        = 4,
  localparam int tag_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   gray_i,
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         binary_o,
  output logic [tag_width_lp-1:0]    tag_o,
  input  logic                       ready_i
);

  logic                    s1_v;
  logic [width_p-1:0]      s1_gray;
  logic [tag_width_lp-1:0] s1_tag;
  logic [width_p-1:0]      s1_bin;
  logic [width_p-1:0]      sel_gray;
  logic [tag_width_lp-1:0] arb_tag;
  logic                    s1_adv;
  logic                    s2_adv;

  assign s2_adv = ~v_o | ready_i;
  assign s1_adv = ~s1_v | s2_adv;

  bsg_g2b_rr_arb #(
    .els_p (els_p)
  ) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (s1_adv),
    .v_i       (v_i),
    .grant_o   (yumi_o),
    .tag_o     (arb_tag)
  );

  always_comb begin
    sel_gray = '0;
    for (int unsigned k = 0; k < els_p; k++) begin
      if (yumi_o[k]) begin
        sel_gray = gray_i[k*width_p +: width_p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v    <= 1'b0;
      s1_gray <= '0;
      s1_tag  <= '0;
    end else if (s1_adv) begin
      s1_v <= |yumi_o;
      if (|yumi_o) begin
        s1_gray <= sel_gray;
        s1_tag  <= arb_tag;
      end
    end
  end

  bsg_gray_to_binary #(
    .width_p (width_p)
  ) conv (
    .gray_i   (s1_gray),
    .binary_o (s1_bin)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o      <= 1'b0;
      binary_o <= '0;
      tag_o    <= '0;
    end else if (s2_adv) begin
      v_o <= s1_v;
      if (s1_v) begin
        binary_o <= s1_bin;
        tag_o    <= s1_tag;
      end
    end
  end

endmodule
